// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multicycle CPU control unit: opcode classes, state
// encodings, ALU operations and datapath mux selects.
package cpu_ctrl_pkg;

  localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;

  // Opcode class is op[5:3]
  localparam logic [2:0] CLS_RALU = 3'b000;
  localparam logic [2:0] CLS_ISE  = 3'b001;
  localparam logic [2:0] CLS_IZE  = 3'b010;
  localparam logic [2:0] CLS_IMM  = 3'b011;
  localparam logic [2:0] CLS_MEM  = 3'b100;
  localparam logic [2:0] CLS_BR   = 3'b101;
  localparam logic [2:0] CLS_JMP  = 3'b110;
  localparam logic [2:0] CLS_SYS  = 3'b111;

  localparam logic [2:0] IMM_LUI = 3'b000;
  localparam logic [2:0] IMM_LI  = 3'b001;
  localparam logic [2:0] JMP_J   = 3'b000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_SE16 = 2'd2;
  localparam logic [1:0] SRCB_ZE16 = 2'd3;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_ZE16   = 2'd1;
  localparam logic [1:0] M2R_MDR    = 2'd2;
  localparam logic [1:0] M2R_SL16   = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_WB_ALU  = 4'd4,
    S_WB_IMM  = 4'd5,
    S_MEM_ADR = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WB  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  typedef struct packed {
    logic [2:0] cls;
    logic       is_store;
    logic       is_abs;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Control bundle between the control FSM (master) and CPU_Datapath (slave).
// No valid/ready handshake: Opcode is sampled and every control is driven each cycle.
interface cpu_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Opcode;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               MemWrite;
  logic               MemAddr;
  logic               IRWrite;
  logic               ALUSrcA;
  logic               RegRead;
  logic               RegWrite;
  logic [1:0]         PCSource;
  logic [1:0]         ALUSrcB;
  logic [1:0]         MemtoReg;
  logic [1:0]         BranchCond;
  logic [2:0]         ALUSelect;
  logic               Halted;
  logic               IllegalOp;
  logic [STATE_W-1:0] State;

  modport master (
    input  Opcode,
    output PCWrite, PCWriteCond, MemWrite, MemAddr, IRWrite, ALUSrcA,
           RegRead, RegWrite, PCSource, ALUSrcB, MemtoReg, BranchCond,
           ALUSelect, Halted, IllegalOp, State
  );

  modport slave (
    output Opcode,
    input  PCWrite, PCWriteCond, MemWrite, MemAddr, IRWrite, ALUSrcA,
           RegRead, RegWrite, PCSource, ALUSrcB, MemtoReg, BranchCond,
           ALUSelect, Halted, IllegalOp, State
  );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder: class, store/absolute flags and legality.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic [5:0] i_opcode,
  output dec_t       o_dec
);

  logic [2:0] w_lo;

  assign w_lo = i_opcode[2:0];

  always_comb begin
    o_dec.cls      = i_opcode[5:3];
    o_dec.is_store = i_opcode[1];
    o_dec.is_abs   = i_opcode[0];
    o_dec.legal    = 1'b0;
    case (i_opcode[5:3])
      CLS_RALU, CLS_ISE, CLS_IZE: o_dec.legal = 1'b1;
      CLS_IMM:  o_dec.legal = (w_lo == IMM_LUI) || (w_lo == IMM_LI);
      // op[2] is reserved in both memory and branch classes
      CLS_MEM:  o_dec.legal = ~i_opcode[2];
      CLS_BR:   o_dec.legal = ~i_opcode[2];
      CLS_JMP:  o_dec.legal = (w_lo == JMP_J);
      CLS_SYS:  o_dec.legal = (i_opcode == HALT_OPCODE);
      default:  o_dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle Moore control unit for CPU_Datapath: fetch, decode, execute,
// memory and writeback, 3-5 cycles per instruction, with a sticky illegal flag.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int         STATE_W     = 4
) (
  input  logic      Clk,
  input  logic      Reset,
  cpu_ctrl_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  dec_t       w_dec;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_mem_write;
  logic       w_mem_addr;
  logic       w_ir_write;
  logic       w_alu_src_a;
  logic       w_reg_write;
  logic [1:0] w_pc_source;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_mem_to_reg;
  logic [1:0] w_branch_cond;
  logic [2:0] w_alu_select;
  logic       w_halted;
  logic       w_reg_read;

  cpu_ctrl_decode #(
    .HALT_OPCODE (HALT_OPCODE)
  ) u_decode (
    .i_opcode (bus.Opcode),
    .o_dec    (w_dec)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_illegal <= 1'b0;
    end else if (r_state == S_DECODE && !w_dec.legal) begin
      r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next          = S_FETCH;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_addr      = 1'b0;
    w_ir_write      = 1'b0;
    w_alu_src_a     = 1'b0;
    w_reg_write     = 1'b0;
    w_pc_source     = PCSRC_ALU;
    w_alu_src_b     = SRCB_B;
    w_mem_to_reg    = M2R_ALUOUT;
    w_branch_cond   = 2'd0;
    w_alu_select    = ALU_ADD;
    w_halted        = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = 1'b1;
        w_alu_src_b = SRCB_ONE;
        w_pc_source = PCSRC_ALU;
        w_pc_write  = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures PC+1+SE(imm) so BRANCH can use it as the target
        w_alu_src_b = SRCB_SE16;
        if (!w_dec.legal) begin
          w_next = S_FETCH;
        end else begin
          case (w_dec.cls)
            CLS_RALU:         w_next = S_EX_R;
            CLS_ISE, CLS_IZE: w_next = S_EX_I;
            CLS_IMM:          w_next = S_WB_IMM;
            CLS_MEM: begin
              if (!w_dec.is_abs)     w_next = S_MEM_ADR;
              else if (w_dec.is_store) w_next = S_MEM_WR;
              else                   w_next = S_MEM_RD;
            end
            CLS_BR:           w_next = S_BRANCH;
            CLS_JMP:          w_next = S_JUMP;
            CLS_SYS:          w_next = S_HALT;
            default:          w_next = S_FETCH;
          endcase
        end
      end
      S_EX_R: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_B;
        w_alu_select = bus.Opcode[2:0];
        w_next       = S_WB_ALU;
      end
      S_EX_I: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = (w_dec.cls == CLS_IZE) ? SRCB_ZE16 : SRCB_SE16;
        w_alu_select = bus.Opcode[2:0];
        w_next       = S_WB_ALU;
      end
      S_WB_ALU: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = M2R_ALUOUT;
        w_next       = S_FETCH;
      end
      S_WB_IMM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (bus.Opcode[2:0] == IMM_LUI) ? M2R_SL16 : M2R_ZE16;
        w_next       = S_FETCH;
      end
      S_MEM_ADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_SE16;
        w_next      = w_dec.is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_mem_addr = w_dec.is_abs;
        w_next     = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = M2R_MDR;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_mem_addr  = w_dec.is_abs;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_src_b     = SRCB_B;
        w_alu_select    = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCSRC_ALUOUT;
        w_branch_cond   = bus.Opcode[1:0];
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = PCSRC_JUMP;
        w_next      = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
        w_next   = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Register-file read port 2 follows the IR directly; A/B reload every cycle
  assign w_reg_read = ((w_dec.cls == CLS_MEM) && w_dec.is_store) || (w_dec.cls == CLS_BR);

  // Write strobes are squashed for the whole time Reset is held
  assign bus.PCWrite     = w_pc_write & ~Reset;
  assign bus.PCWriteCond = w_pc_write_cond & ~Reset;
  assign bus.MemWrite    = w_mem_write & ~Reset;
  assign bus.IRWrite     = w_ir_write & ~Reset;
  assign bus.RegWrite    = w_reg_write & ~Reset;
  assign bus.MemAddr     = w_mem_addr;
  assign bus.ALUSrcA     = w_alu_src_a;
  assign bus.RegRead     = w_reg_read;
  assign bus.PCSource    = w_pc_source;
  assign bus.ALUSrcB     = w_alu_src_b;
  assign bus.MemtoReg    = w_mem_to_reg;
  assign bus.BranchCond  = w_branch_cond;
  assign bus.ALUSelect   = w_alu_select;
  assign bus.Halted      = w_halted;
  assign bus.IllegalOp   = r_illegal;
  assign bus.State       = STATE_W'(r_state);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-instruction expected control words are queued
// by the driver from an instruction-level model and checked each cycle by a monitor.
module tb_cpu_control_fsm;
  import cpu_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_write;
    logic       mem_addr;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_read;
    logic       reg_write;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] mem_to_reg;
    logic [1:0] branch_cond;
    logic [2:0] alu_select;
    logic       halted;
    logic       illegal;
  } ctl_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [24:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  bit m_illegal = 1'b0;

  cpu_ctrl_if #(.STATE_W(4)) bus ();

  cpu_control_fsm #(
    .HALT_OPCODE (6'b111111),
    .STATE_W     (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, queue depth=%0d", exp_q.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- reference model ----------------
  function automatic bit legal_op(logic [5:0] op);
    logic [2:0] lo;
    lo = op[2:0];
    case (op[5:3])
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b011: return (lo == 3'b000) || (lo == 3'b001);
      3'b100, 3'b101: return !op[2];
      3'b110: return lo == 3'b000;
      default: return op == 6'b111111;
    endcase
  endfunction

  function automatic ctl_t blank(state_t st, logic [5:0] op);
    ctl_t c;
    c = '0;
    c.state = st;
    c.reg_read = ((op[5:3] == 3'b100) && op[1]) || (op[5:3] == 3'b101);
    c.illegal = m_illegal;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t a;
    a.state         = bus.State;
    a.pc_write      = bus.PCWrite;
    a.pc_write_cond = bus.PCWriteCond;
    a.mem_write     = bus.MemWrite;
    a.mem_addr      = bus.MemAddr;
    a.ir_write      = bus.IRWrite;
    a.alu_src_a     = bus.ALUSrcA;
    a.reg_read      = bus.RegRead;
    a.reg_write     = bus.RegWrite;
    a.pc_source     = bus.PCSource;
    a.alu_src_b     = bus.ALUSrcB;
    a.mem_to_reg    = bus.MemtoReg;
    a.branch_cond   = bus.BranchCond;
    a.alu_select    = bus.ALUSelect;
    a.halted        = bus.Halted;
    a.illegal       = bus.IllegalOp;
    return a;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue one instruction's per-cycle control words; n = cycles it occupies
  task automatic issue(input logic [5:0] op, output int n);
    ctl_t c;
    bus.Opcode = op;
    c = blank(S_FETCH, op);
    c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'd1;
    exp_q.push_back(c);
    c = blank(S_DECODE, op);
    c.alu_src_b = 2'd2;
    exp_q.push_back(c);
    n = 2;
    if (!legal_op(op)) begin
      m_illegal = 1'b1;
      return;
    end
    case (op[5:3])
      3'b000, 3'b001, 3'b010: begin
        c = blank(op[5:3] == 3'b000 ? S_EX_R : S_EX_I, op);
        c.alu_src_a = 1'b1;
        c.alu_src_b = (op[5:3] == 3'b000) ? 2'd0 : (op[5:3] == 3'b010) ? 2'd3 : 2'd2;
        c.alu_select = op[2:0];
        exp_q.push_back(c);
        c = blank(S_WB_ALU, op);
        c.reg_write = 1'b1;
        exp_q.push_back(c);
        n = 4;
      end
      3'b011: begin
        c = blank(S_WB_IMM, op);
        c.reg_write = 1'b1;
        c.mem_to_reg = op[0] ? 2'd1 : 2'd3;
        exp_q.push_back(c);
        n = 3;
      end
      3'b100: begin
        if (!op[0]) begin
          c = blank(S_MEM_ADR, op);
          c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
          exp_q.push_back(c);
          n++;
        end
        if (op[1]) begin
          c = blank(S_MEM_WR, op);
          c.mem_write = 1'b1; c.mem_addr = op[0];
          exp_q.push_back(c);
          n++;
        end else begin
          c = blank(S_MEM_RD, op);
          c.mem_addr = op[0];
          exp_q.push_back(c);
          c = blank(S_MEM_WB, op);
          c.reg_write = 1'b1; c.mem_to_reg = 2'd2;
          exp_q.push_back(c);
          n += 2;
        end
      end
      3'b101: begin
        c = blank(S_BRANCH, op);
        c.alu_src_a = 1'b1; c.alu_select = 3'b001; c.pc_write_cond = 1'b1;
        c.pc_source = 2'd1; c.branch_cond = op[1:0];
        exp_q.push_back(c);
        n = 3;
      end
      3'b110: begin
        c = blank(S_JUMP, op);
        c.pc_write = 1'b1; c.pc_source = 2'd2;
        exp_q.push_back(c);
        n = 3;
      end
      default: begin
        c = blank(S_HALT, op);
        c.halted = 1'b1;
        for (int i = 0; i < 24; i++) exp_q.push_back(c);
        n = 26;
      end
    endcase
  endtask

  task automatic run(input logic [5:0] op);
    int n;
    issue(op, n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    ctl_t e;
    ctl_t a;
    if (!Reset && exp_q.size() > 0) begin
      e = ctl_t'(exp_q.pop_front());
      a = sample();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ctl_word op=%b state=%0d: got %h expected %h", bus.Opcode, e.state, a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [5:0] dir_ops[12];
    dir_ops = '{6'b000010, 6'b100000, 6'b100011, 6'b101010, 6'b100001, 6'b100010,
                6'b011000, 6'b011001, 6'b001101, 6'b010110, 6'b110000, 6'b011111};
    bus.Opcode = 6'b000000;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", 32'(bus.State), 32'(S_FETCH));
    check("reset_illegal", 32'(bus.IllegalOp), 32'd0);
    check("reset_pcwrite", 32'(bus.PCWrite), 32'd0);
    check("reset_irwrite", 32'(bus.IRWrite), 32'd0);
    Reset = 1'b0;

    foreach (dir_ops[i]) run(dir_ops[i]);

    // Reset pulsed in the middle of a store
    issue(6'b100011, n);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("midreset_state", 32'(bus.State), 32'(S_FETCH));
    check("midreset_memwrite", 32'(bus.MemWrite), 32'd0);
    check("midreset_irwrite", 32'(bus.IRWrite), 32'd0);
    check("midreset_pcwrite", 32'(bus.PCWrite), 32'd0);
    check("midreset_illegal_clr", 32'(bus.IllegalOp), 32'd0);
    @(posedge Clk);
    #1;
    m_illegal = 1'b0;
    Reset = 1'b0;

    run(6'b000111);
    for (int i = 0; i < 60; i++) run(6'($urandom_range(0, 62)));

    run(6'b111111);
    check("halt_flag", 32'(bus.Halted), 32'd1);
    check("halt_memwrite", 32'(bus.MemWrite), 32'd0);
    Reset = 1'b1;
    #1;
    check("halt_reset_state", 32'(bus.State), 32'(S_FETCH));
    check("halt_reset_halted", 32'(bus.Halted), 32'd0);
    @(posedge Clk);
    #1;
    m_illegal = 1'b0;
    Reset = 1'b0;
    run(6'b101001);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
